// File: rtl/rx_frame_pkg.sv
// Shared encodings and constants for the serial frame decoder
// that feeds the seven-segment display driver.
package rx_frame_pkg;

   typedef enum logic [1:0] {
      FR_WAIT_SYNC,
      FR_GET_HI,
      FR_GET_LO,
      FR_GET_SUM
   } frame_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam logic [7:0] MAX_DIGIT_PAIR    = 8'd99;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Each display byte is shown as two decimal digits.
   function automatic logic digit_pair_ok(input logic [7:0] b);
      return (b <= MAX_DIGIT_PAIR);
   endfunction

endpackage

// File: rtl/rx_frame_decoder_if.sv
// Display value bus between the frame decoder (master) and the
// seven-segment display driver (slave).
interface rx_frame_decoder_if;
   logic [15:0] A;
   logic        frame_ok;
   logic        frame_err;

   modport master (output A, output frame_ok, output frame_err);
   modport slave  (input  A, input  frame_ok, input  frame_err);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, start-bit qualification,
// mid-bit sampling and stop-bit check.
//
// state    | meaning
// ---------+---------------------------------------------------------
// RX_IDLE  | line idle, waiting for a 1->0 edge on the synced line
// RX_START | half-bit wait, then confirm the start bit is still low
// RX_DATA  | sample 8 data bits one bit period apart, LSB first
// RX_STOP  | sample the stop bit; pulse byte_valid or byte_ferr
module uart_rx_byte
   import rx_frame_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       byte_ferr
);

   localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

   rx_state_t        r_state;
   logic             r_sync1;
   logic             r_rxs;
   logic             r_rxs_q;
   logic [CNT_W-1:0] r_baud_cnt;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shift;
   logic             r_byte_valid;
   logic             r_byte_ferr;
   logic             w_fall;

   assign w_fall = r_rxs_q & ~r_rxs;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= RX_IDLE;
         r_sync1      <= 1'b1;
         r_rxs        <= 1'b1;
         r_rxs_q      <= 1'b1;
         r_baud_cnt   <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_byte_valid <= 1'b0;
         r_byte_ferr  <= 1'b0;
      end else begin
         r_sync1      <= rxd;
         r_rxs        <= r_sync1;
         r_rxs_q      <= r_rxs;
         r_byte_valid <= 1'b0;
         r_byte_ferr  <= 1'b0;

         case (r_state)
            RX_IDLE: begin
               if (w_fall) begin
                  r_state    <= RX_START;
                  r_baud_cnt <= HALF_LOAD;
                  r_bit_cnt  <= '0;
               end
            end

            RX_START: begin
               if (r_baud_cnt == '0) begin
                  // A start bit that has gone high by mid-bit is line noise.
                  if (!r_rxs) begin
                     r_state    <= RX_DATA;
                     r_baud_cnt <= BIT_LOAD;
                  end else begin
                     r_state <= RX_IDLE;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt - 1'b1;
               end
            end

            RX_DATA: begin
               if (r_baud_cnt == '0) begin
                  r_shift    <= {r_rxs, r_shift[7:1]};
                  r_baud_cnt <= BIT_LOAD;
                  r_bit_cnt  <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= RX_STOP;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt - 1'b1;
               end
            end

            RX_STOP: begin
               if (r_baud_cnt == '0) begin
                  r_state <= RX_IDLE;
                  if (r_rxs) begin
                     r_byte_valid <= 1'b1;
                  end else begin
                     r_byte_ferr <= 1'b1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt - 1'b1;
               end
            end

            default: r_state <= RX_IDLE;
         endcase
      end
   end

   assign byte_out   = r_shift;
   assign byte_valid = r_byte_valid;
   assign byte_ferr  = r_byte_ferr;

endmodule

// File: rtl/rx_frame_decoder.sv
// Assembles {SYNC, hi, lo, sum} frames from the UART byte stream and
// updates the display value when a frame checks out.
//
// state        | meaning
// -------------+-----------------------------------------------------
// FR_WAIT_SYNC | hunting for the sync byte; other bytes are dropped
// FR_GET_HI    | next byte is the high display byte
// FR_GET_LO    | next byte is the low display byte
// FR_GET_SUM   | next byte is the 8-bit checksum; accept or reject
module rx_frame_decoder
   import rx_frame_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
   parameter int         GAP_BITS     = 20
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              rxd,
   rx_frame_decoder_if.master disp
);

   localparam int               GAP_CYC  = GAP_BITS * CLKS_PER_BIT;
   localparam int               GAP_W    = $clog2(GAP_CYC);
   // Terminal count at zero plus the registered error pulse lands the
   // timeout exactly GAP_CYC cycles after the byte_valid that armed it.
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 2);

   frame_state_t     r_state;
   logic [7:0]       r_hi;
   logic [7:0]       r_lo;
   logic [15:0]      r_a;
   logic             r_ok;
   logic             r_err;
   logic [GAP_W-1:0] r_gap_cnt;

   logic [7:0]       w_byte;
   logic             w_byte_valid;
   logic             w_byte_ferr;
   logic [7:0]       w_sum;
   logic             w_frame_good;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .byte_out   (w_byte),
      .byte_valid (w_byte_valid),
      .byte_ferr  (w_byte_ferr)
   );

   assign w_sum        = r_hi + r_lo;
   assign w_frame_good = (w_byte == w_sum) && digit_pair_ok(r_hi) && digit_pair_ok(r_lo);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= FR_WAIT_SYNC;
         r_hi      <= '0;
         r_lo      <= '0;
         r_a       <= '0;
         r_ok      <= 1'b0;
         r_err     <= 1'b0;
         r_gap_cnt <= GAP_LOAD;
      end else begin
         r_ok  <= 1'b0;
         r_err <= 1'b0;

         if (w_byte_ferr) begin
            if (r_state != FR_WAIT_SYNC) begin
               r_err <= 1'b1;
            end
            r_state <= FR_WAIT_SYNC;
         end else if (w_byte_valid) begin
            // A byte arriving on the timeout cycle still counts.
            r_gap_cnt <= GAP_LOAD;
            case (r_state)
               FR_WAIT_SYNC: begin
                  if (w_byte == SYNC_BYTE) begin
                     r_state <= FR_GET_HI;
                  end
               end
               FR_GET_HI: begin
                  r_hi    <= w_byte;
                  r_state <= FR_GET_LO;
               end
               FR_GET_LO: begin
                  r_lo    <= w_byte;
                  r_state <= FR_GET_SUM;
               end
               FR_GET_SUM: begin
                  if (w_frame_good) begin
                     r_a  <= {r_hi, r_lo};
                     r_ok <= 1'b1;
                  end else begin
                     r_err <= 1'b1;
                  end
                  r_state <= FR_WAIT_SYNC;
               end
               default: r_state <= FR_WAIT_SYNC;
            endcase
         end else if (r_state != FR_WAIT_SYNC) begin
            if (r_gap_cnt == '0) begin
               r_err   <= 1'b1;
               r_state <= FR_WAIT_SYNC;
            end else begin
               r_gap_cnt <= r_gap_cnt - 1'b1;
            end
         end
      end
   end

   assign disp.A         = r_a;
   assign disp.frame_ok  = r_ok;
   assign disp.frame_err = r_err;

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Directed bench for rx_frame_decoder: table of whole frames plus
// hand-written reset, framing-error, gap-timeout and glitch sequences.
module tb_rx_frame_decoder;

   localparam int CPB = 8;
   localparam int GAP = 20;
   localparam int BYTE_CYC = 10 * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd = 1'b1;

   rx_frame_decoder_if disp ();

   rx_frame_decoder #(
      .CLKS_PER_BIT (CPB),
      .SYNC_BYTE    (8'hA5),
      .GAP_BITS     (GAP)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .rxd  (rxd),
      .disp (disp)
   );

   always #5 clk = ~clk;

   int cyc          = 0;
   int ok_cycles    = 0;
   int err_cycles   = 0;
   int both_cycles  = 0;
   int last_ok_cyc  = -1;
   int last_err_cyc = -1;
   int checks       = 0;
   int passes       = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (disp.frame_ok) begin
            ok_cycles++;
            last_ok_cyc = cyc;
         end
         if (disp.frame_err) begin
            err_cycles++;
            last_err_cyc = cyc;
         end
         if (disp.frame_ok && disp.frame_err) both_cycles++;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic align();
      @(posedge clk);
      #2;
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      repeat (CPB) @(posedge clk);
      #2;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
      rxd = 1'b1;
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(posedge clk);
      #2;
   endtask

   typedef struct {
      int          n;
      logic [7:0]  b [6];
      int          exp_ok;
      int          exp_err;
      logic [15:0] exp_a;
   } vec_t;

   function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic [7:0] b4, input logic [7:0] b5,
                               input int ok, input int err, input logic [15:0] a);
      vec_t v;
      v.n = n;
      v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
      v.b[3] = b3; v.b[4] = b4; v.b[5] = b5;
      v.exp_ok = ok;
      v.exp_err = err;
      v.exp_a = a;
      return v;
   endfunction

   vec_t vecs [8];

   initial begin
      int ok0, err0, t0;

      vecs[0] = mk(4, 8'hA5, 8'h12, 8'h34, 8'h46, 8'h00, 8'h00, 1, 0, 16'h1234);
      vecs[1] = mk(4, 8'hA5, 8'h00, 8'h63, 8'h63, 8'h00, 8'h00, 1, 0, 16'h0063);
      vecs[2] = mk(4, 8'hA5, 8'h12, 8'h34, 8'h47, 8'h00, 8'h00, 0, 1, 16'h0063);
      vecs[3] = mk(4, 8'hA5, 8'h64, 8'h00, 8'h64, 8'h00, 8'h00, 0, 1, 16'h0063);
      vecs[4] = mk(4, 8'hA5, 8'h00, 8'h64, 8'h64, 8'h00, 8'h00, 0, 1, 16'h0063);
      vecs[5] = mk(4, 8'hA5, 8'h63, 8'h63, 8'hC6, 8'h00, 8'h00, 1, 0, 16'h6363);
      vecs[6] = mk(4, 8'hA5, 8'hA5, 8'hA5, 8'h4A, 8'h00, 8'h00, 0, 1, 16'h6363);
      vecs[7] = mk(6, 8'h00, 8'hFF, 8'hA5, 8'h02, 8'h03, 8'h05, 1, 0, 16'h0203);

      // Reset held for three cycles with the line idle.
      rst = 1'b1;
      rxd = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("reset_A", int'(disp.A), 0);
      check("reset_ok", int'(disp.frame_ok), 0);
      check("reset_err", int'(disp.frame_err), 0);
      rst = 1'b0;
      idle(10);

      for (int k = 0; k < 8; k++) begin
         ok0  = ok_cycles;
         err0 = err_cycles;
         align();
         t0 = cyc;
         for (int j = 0; j < vecs[k].n; j++) send_byte(vecs[k].b[j], 1'b1);
         idle(40);
         check($sformatf("vec%0d_A", k), int'(disp.A), int'(vecs[k].exp_a));
         check($sformatf("vec%0d_ok_cycles", k), ok_cycles - ok0, vecs[k].exp_ok);
         check($sformatf("vec%0d_err_cycles", k), err_cycles - err0, vecs[k].exp_err);
         if (vecs[k].exp_ok != 0)
            check($sformatf("vec%0d_ok_latency", k), last_ok_cyc - t0, BYTE_CYC * vecs[k].n);
         if (vecs[k].exp_err != 0)
            check($sformatf("vec%0d_err_latency", k), last_err_cyc - t0, BYTE_CYC * vecs[k].n);
      end

      // Stop bit low on the hi byte, then a clean frame.
      ok0  = ok_cycles;
      err0 = err_cycles;
      align();
      t0 = cyc;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h12, 1'b0);
      idle(40);
      check("ferr_err_cycles", err_cycles - err0, 1);
      check("ferr_err_latency", last_err_cyc - t0, 2 * BYTE_CYC);
      check("ferr_ok_cycles", ok_cycles - ok0, 0);
      check("ferr_A_kept", int'(disp.A), 16'h0203);
      align();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1);
      idle(40);
      check("after_ferr_A", int'(disp.A), 16'h0102);
      check("after_ferr_ok_cycles", ok_cycles - ok0, 1);

      // Gap timeout after sync + hi, then orphaned tail bytes.
      ok0  = ok_cycles;
      err0 = err_cycles;
      align();
      t0 = cyc;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h05, 1'b1);
      idle(161 * CPB);
      check("gap_err_cycles", err_cycles - err0, 1);
      check("gap_err_latency", last_err_cyc - t0, 2 * BYTE_CYC - 1 + GAP * CPB);
      align();
      send_byte(8'h07, 1'b1);
      send_byte(8'h07, 1'b1);
      send_byte(8'h0E, 1'b1);
      idle(40);
      check("gap_tail_ok_cycles", ok_cycles - ok0, 0);
      check("gap_tail_err_cycles", err_cycles - err0, 1);
      check("gap_tail_A", int'(disp.A), 16'h0102);

      // Short low glitch between sync and hi must not become a byte.
      ok0  = ok_cycles;
      err0 = err_cycles;
      align();
      send_byte(8'hA5, 1'b1);
      rxd = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      idle(20);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h46, 1'b1);
      idle(40);
      check("glitch_A", int'(disp.A), 16'h1234);
      check("glitch_ok_cycles", ok_cycles - ok0, 1);
      check("glitch_err_cycles", err_cycles - err0, 0);

      // Reset while the lo byte is on the wire.
      ok0  = ok_cycles;
      err0 = err_cycles;
      align();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h12, 1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rst = 1'b1;
      rxd = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check("midrst_A", int'(disp.A), 0);
      rst = 1'b0;
      idle(20);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h07, 1'b1);
      send_byte(8'h08, 1'b1);
      send_byte(8'h0F, 1'b1);
      idle(40);
      check("midrst_next_A", int'(disp.A), 16'h0708);
      check("midrst_ok_cycles", ok_cycles - ok0, 1);
      check("midrst_err_cycles", err_cycles - err0, 0);

      check("ok_err_overlap", both_cycles, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
